// File: rtl/device_mux_param.sv
// device_mux_param
// Registered address decoder / bus mux between one 16-bit master (m68k bus
// wrapper) and NUM_SLAVES peripherals. The address is decoded against a
// base/mask table, the transaction is latched, the strobes are forwarded to
// the selected slave, and that slave's data/ack is returned. Unmapped
// addresses produce master_berr.
//
// Optional feature macro: DEVICE_MUX_TIMEOUT_EN
//   defined   : an ACCESS that runs TIMEOUT_CYCLES cycles without an ack ends
//               in ERROR (master_berr)
//   undefined : no counter is built; ACCESS waits for slave_ack indefinitely
//
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   master_write   write data from CPU
//   master_read    read data to CPU (registered)
//   master_addr    byte address from CPU
//   master_uds/lds upper/lower data strobes, active-high
//   master_ack     transfer acknowledge (registered)
//   master_berr    bus error (registered)
//   slave_read     packed read data, slave i at [16*i+:16]
//   slave_write    latched write data, shared
//   slave_addr     latched master_addr[SLAVE_ADDR_W-1:0], shared
//   slave_uds/lds  one-hot strobes to the selected slave
//   slave_ack      per-slave acknowledge
module device_mux_param #(
   parameter int unsigned NUM_SLAVES     = 5,
   parameter int unsigned SLAVE_ADDR_W   = 24,
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
      {32'h0010_0300, 32'h0010_0200, 32'h0010_0100, 32'h0010_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
      {{4{32'hFFFF_FF00}}, 32'hFFF0_0000},
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [15:0]               master_write,
   output logic [15:0]               master_read,
   input  logic [31:0]               master_addr,
   input  logic                      master_uds,
   input  logic                      master_lds,
   output logic                      master_ack,
   output logic                      master_berr,
   input  logic [16*NUM_SLAVES-1:0]  slave_read,
   output logic [15:0]               slave_write,
   output logic [SLAVE_ADDR_W-1:0]   slave_addr,
   output logic [NUM_SLAVES-1:0]     slave_uds,
   output logic [NUM_SLAVES-1:0]     slave_lds,
   input  logic [NUM_SLAVES-1:0]     slave_ack
);

   localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   // Parameter sanity checks at elaboration
   if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
      $error("device_mux_param: NUM_SLAVES must be 1..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("device_mux_param: TIMEOUT_CYCLES must be 1..65535");
   end

   logic [1:0]              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [15:0]             master_read_q, master_read_d;
   logic                    master_ack_q, master_ack_d;
   logic                    master_berr_q, master_berr_d;
   logic [15:0]             slave_write_q, slave_write_d;
   logic [SLAVE_ADDR_W-1:0] slave_addr_q, slave_addr_d;
   logic [NUM_SLAVES-1:0]   slave_uds_q, slave_uds_d;
   logic [NUM_SLAVES-1:0]   slave_lds_q, slave_lds_d;

   logic                    hit;
   logic [IDX_W-1:0]        hit_idx;
   logic                    sel_ack;
   logic [15:0]             sel_read;
   logic                    master_req;

`ifdef DEVICE_MUX_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

   assign master_req = master_uds | master_lds;

   // Address decode: iterate high to low so the lowest matching index wins
   always_comb begin : p_decode
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
         if ((master_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Return path: only the latched slave's ack/data is ever looked at
   always_comb begin : p_return_mux
      sel_ack  = 1'b0;
      sel_read = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_ack  = slave_ack[i];
            sel_read = slave_read[16*i +: 16];
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin : p_next
      state_d       = state_q;
      idx_d         = idx_q;
      master_read_d = master_read_q;
      master_ack_d  = master_ack_q;
      master_berr_d = master_berr_q;
      slave_write_d = slave_write_q;
      slave_addr_d  = slave_addr_q;
      slave_uds_d   = slave_uds_q;
      slave_lds_d   = slave_lds_q;
`ifdef DEVICE_MUX_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (master_req) begin
               slave_write_d = master_write;
               slave_addr_d  = master_addr[SLAVE_ADDR_W-1:0];
               idx_d         = hit_idx;
               if (hit) begin
                  state_d     = ST_ACCESS;
                  slave_uds_d = NUM_SLAVES'(master_uds) << hit_idx;
                  slave_lds_d = NUM_SLAVES'(master_lds) << hit_idx;
               end else begin
                  state_d       = ST_ERROR;
                  master_berr_d = 1'b1;
               end
            end
         end

         ST_ACCESS: begin
            if (!master_req) begin
               // Master abandoned the cycle: quietly release the slave
               state_d     = ST_IDLE;
               slave_uds_d = '0;
               slave_lds_d = '0;
            end else if (sel_ack) begin
               // Ack has priority over a coincident timeout
               state_d       = ST_DONE;
               master_ack_d  = 1'b1;
               master_read_d = sel_read;
               slave_uds_d   = '0;
               slave_lds_d   = '0;
            end
`ifdef DEVICE_MUX_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d       = ST_ERROR;
               master_berr_d = 1'b1;
               slave_uds_d   = '0;
               slave_lds_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end

         ST_DONE: begin
            if (!master_req) begin
               state_d      = ST_IDLE;
               master_ack_d = 1'b0;
            end
         end

         ST_ERROR: begin
            if (!master_req) begin
               state_d       = ST_IDLE;
               master_berr_d = 1'b0;
            end
         end

         default: begin
            state_d       = ST_IDLE;
            master_ack_d  = 1'b0;
            master_berr_d = 1'b0;
            slave_uds_d   = '0;
            slave_lds_d   = '0;
         end
      endcase

`ifdef DEVICE_MUX_TIMEOUT_EN
      if (state_d == ST_IDLE) begin
         cnt_d = '0;
      end
`endif
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin : p_regs
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         master_read_q <= '0;
         master_ack_q  <= 1'b0;
         master_berr_q <= 1'b0;
         slave_write_q <= '0;
         slave_addr_q  <= '0;
         slave_uds_q   <= '0;
         slave_lds_q   <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         master_read_q <= master_read_d;
         master_ack_q  <= master_ack_d;
         master_berr_q <= master_berr_d;
         slave_write_q <= slave_write_d;
         slave_addr_q  <= slave_addr_d;
         slave_uds_q   <= slave_uds_d;
         slave_lds_q   <= slave_lds_d;
      end
   end

`ifdef DEVICE_MUX_TIMEOUT_EN
   // ACCESS-cycle counter for the no-ack timeout
   always_ff @(posedge clk or negedge reset_n) begin : p_cnt
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign master_read = master_read_q;
   assign master_ack  = master_ack_q;
   assign master_berr = master_berr_q;
   assign slave_write = slave_write_q;
   assign slave_addr  = slave_addr_q;
   assign slave_uds   = slave_uds_q;
   assign slave_lds   = slave_lds_q;

endmodule

// File: tb/tb_device_mux_param.sv
// Testbench for device_mux_param: directed vector table plus hand-written
// sequences for reset, abort and the no-ack (timeout / long wait) case.
module tb_device_mux_param;

   localparam int unsigned NS = 5;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [15:0]       master_write;
   logic [15:0]       master_read;
   logic [31:0]       master_addr;
   logic              master_uds;
   logic              master_lds;
   logic              master_ack;
   logic              master_berr;
   logic [16*NS-1:0]  slave_read;
   logic [15:0]       slave_write;
   logic [23:0]       slave_addr;
   logic [NS-1:0]     slave_uds;
   logic [NS-1:0]     slave_lds;
   logic [NS-1:0]     slave_ack;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   device_mux_param #(
      .NUM_SLAVES     (NS),
      .SLAVE_ADDR_W   (24),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .master_write (master_write),
      .master_read  (master_read),
      .master_addr  (master_addr),
      .master_uds   (master_uds),
      .master_lds   (master_lds),
      .master_ack   (master_ack),
      .master_berr  (master_berr),
      .slave_read   (slave_read),
      .slave_write  (slave_write),
      .slave_addr   (slave_addr),
      .slave_uds    (slave_uds),
      .slave_lds    (slave_lds),
      .slave_ack    (slave_ack)
   );

   typedef struct {
      logic [31:0]   addr;
      logic [15:0]   wdata;
      logic          uds;
      logic          lds;
      int            ack_idx;   // -1: unmapped, expect bus error
      int            delay;     // ACCESS cycles before the ack
      logic [NS-1:0] stray;     // acks pulsed on other slaves while waiting
      logic [15:0]   rdata;
      logic [NS-1:0] exp_uds;
      logic [NS-1:0] exp_lds;
      logic          exp_berr;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Give every lane a distinct filler so a wrong index shows up in master_read
   task automatic set_lanes(input int idx, input logic [15:0] val);
      for (int i = 0; i < int'(NS); i++) begin
         slave_read[16*i +: 16] = 16'hE000 | 16'(i);
      end
      if (idx >= 0) slave_read[16*idx +: 16] = val;
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, ".read"},  32'(master_read), 32'h0);
      chk({nm, ".ack"},   32'(master_ack),  32'h0);
      chk({nm, ".berr"},  32'(master_berr), 32'h0);
      chk({nm, ".suds"},  32'(slave_uds),   32'h0);
      chk({nm, ".slds"},  32'(slave_lds),   32'h0);
      chk({nm, ".swr"},   32'(slave_write), 32'h0);
      chk({nm, ".saddr"}, 32'(slave_addr),  32'h0);
   endtask

   // Drive a request and let the IDLE edge latch it; returns at that posedge
   task automatic start_access(input logic [31:0] a, input logic [15:0] d,
                               input logic u, input logic l);
      @(negedge clk);
      master_addr  = a;
      master_write = d;
      master_uds   = u;
      master_lds   = l;
      @(posedge clk);
   endtask

   task automatic run_vec(input int n, input vec_t v);
      string nm;
      nm = $sformatf("v%0d", n);
      set_lanes(v.ack_idx, v.rdata);
      start_access(v.addr, v.wdata, v.uds, v.lds);
      @(negedge clk);
      // These changes must not reach the latched outputs
      master_addr  = ~v.addr;
      master_write = ~v.wdata;
      chk({nm, ".uds"},   32'(slave_uds),   32'(v.exp_uds));
      chk({nm, ".lds"},   32'(slave_lds),   32'(v.exp_lds));
      chk({nm, ".berr"},  32'(master_berr), 32'(v.exp_berr));
      chk({nm, ".ack0"},  32'(master_ack),  32'h0);
      chk({nm, ".saddr"}, 32'(slave_addr),  32'(v.addr[23:0]));
      chk({nm, ".swr"},   32'(slave_write), 32'(v.wdata));
      if (v.ack_idx < 0) begin
         @(posedge clk); @(negedge clk);
         chk({nm, ".berr_hold"}, 32'(master_berr), 32'h1);
         master_uds = 1'b0;
         master_lds = 1'b0;
         @(posedge clk); @(negedge clk);
         chk({nm, ".berr_clr"}, 32'(master_berr), 32'h0);
      end else begin
         for (int d = 0; d < v.delay; d++) begin
            slave_ack = v.stray;
            @(posedge clk); @(negedge clk);
            chk({nm, ".wait_uds"}, 32'(slave_uds),  32'(v.exp_uds));
            chk({nm, ".wait_ack"}, 32'(master_ack), 32'h0);
         end
         slave_ack = '0;
         slave_ack[v.ack_idx] = 1'b1;
         @(posedge clk); @(negedge clk);
         slave_ack = '0;
         chk({nm, ".ack"},      32'(master_ack),  32'h1);
         chk({nm, ".read"},     32'(master_read), 32'(v.rdata));
         chk({nm, ".done_uds"}, 32'(slave_uds | slave_lds), 32'h0);
         chk({nm, ".done_berr"},32'(master_berr), 32'h0);
         @(posedge clk); @(negedge clk);
         chk({nm, ".ack_hold"}, 32'(master_ack),  32'h1);
         chk({nm, ".read_hold"},32'(master_read), 32'(v.rdata));
         master_uds = 1'b0;
         master_lds = 1'b0;
         @(posedge clk); @(negedge clk);
         chk({nm, ".ack_clr"},  32'(master_ack),  32'h0);
      end
   endtask

   initial begin
      //        addr           wdata     u     l     ack delay stray     rdata     exp_uds   exp_lds   berr
      vecs[0] = '{32'h0000_0100, 16'h1111, 1'b1, 1'b1,  0, 2, 5'b00000, 16'hBEEF, 5'b00001, 5'b00001, 1'b0};
      vecs[1] = '{32'h0010_0104, 16'h00A5, 1'b0, 1'b1,  2, 0, 5'b00000, 16'h0F0F, 5'b00000, 5'b00100, 1'b0};
      vecs[2] = '{32'h0020_0000, 16'h2222, 1'b1, 1'b1, -1, 0, 5'b00000, 16'h0000, 5'b00000, 5'b00000, 1'b1};
      vecs[3] = '{32'h0010_0010, 16'h3333, 1'b1, 1'b1,  1, 3, 5'b00001, 16'h1234, 5'b00010, 5'b00010, 1'b0};
      vecs[4] = '{32'h0010_03FE, 16'h4444, 1'b1, 1'b0,  4, 1, 5'b01001, 16'hCAFE, 5'b10000, 5'b00000, 1'b0};
      vecs[5] = '{32'h0010_0280, 16'h5555, 1'b1, 1'b1,  3, 0, 5'b00000, 16'h5A5A, 5'b01000, 5'b01000, 1'b0};
      vecs[6] = '{32'h0010_0400, 16'h6666, 1'b0, 1'b1, -1, 0, 5'b00000, 16'h0000, 5'b00000, 5'b00000, 1'b1};
      vecs[7] = '{32'h000F_FFFE, 16'h7777, 1'b1, 1'b1,  0, 1, 5'b11110, 16'h0001, 5'b00001, 5'b00001, 1'b0};
      vecs[8] = '{32'hFF00_0000, 16'h8888, 1'b1, 1'b0, -1, 0, 5'b00000, 16'h0000, 5'b00000, 5'b00000, 1'b1};

      reset_n      = 1'b0;
      master_addr  = '0;
      master_write = '0;
      master_uds   = 1'b0;
      master_lds   = 1'b0;
      slave_ack    = '0;
      set_lanes(-1, 16'h0);
      #12;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check_all_zero("post_reset");

      for (int n = 0; n < 9; n++) begin
         run_vec(n, vecs[n]);
      end

      // Abort: master drops strobes mid-ACCESS, a late ack must be ignored
      set_lanes(1, 16'h9999);
      start_access(32'h0010_0000, 16'hABCD, 1'b1, 1'b1);
      @(negedge clk);
      chk("abort.uds", 32'(slave_uds), 32'h02);
      master_uds = 1'b0;
      master_lds = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("abort.strobes", 32'(slave_uds | slave_lds), 32'h0);
      chk("abort.ack",     32'(master_ack),  32'h0);
      chk("abort.berr",    32'(master_berr), 32'h0);
      slave_ack = 5'b00010;
      @(posedge clk); @(negedge clk);
      slave_ack = '0;
      chk("abort.late_ack", 32'(master_ack), 32'h0);

      // Asynchronous reset in the middle of an access to slave 2
      start_access(32'h0010_0100, 16'h4321, 1'b1, 1'b1);
      @(negedge clk);
      chk("areset.pre_uds", 32'(slave_uds), 32'h04);
      #2 reset_n = 1'b0;
      #1 check_all_zero("areset");
      @(negedge clk);
      master_uds = 1'b0;
      master_lds = 1'b0;
      reset_n    = 1'b1;
      @(posedge clk); @(negedge clk);
      check_all_zero("areset_rel");
      run_vec(100, vecs[5]);

      // Slave 3 never acks in time
      set_lanes(3, 16'h7E57);
      start_access(32'h0010_0200, 16'h0000, 1'b1, 1'b1);
`ifdef DEVICE_MUX_TIMEOUT_EN
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("tmo.uds",  32'(slave_uds),   32'h08);
         chk("tmo.berr", 32'(master_berr), 32'h0);
         @(posedge clk);
      end
      @(negedge clk);
      chk("tmo.berr_set", 32'(master_berr), 32'h1);
      chk("tmo.uds_drop", 32'(slave_uds),   32'h0);
      chk("tmo.ack",      32'(master_ack),  32'h0);
      master_uds = 1'b0;
      master_lds = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("tmo.berr_clr", 32'(master_berr), 32'h0);
`else
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("wait.uds",  32'(slave_uds),   32'h08);
         chk("wait.berr", 32'(master_berr), 32'h0);
         @(posedge clk);
      end
      @(negedge clk);
      slave_ack = 5'b01000;
      @(posedge clk); @(negedge clk);
      slave_ack = '0;
      chk("wait.ack",  32'(master_ack),  32'h1);
      chk("wait.read", 32'(master_read), 32'h7E57);
      chk("wait.berr_after", 32'(master_berr), 32'h0);
      master_uds = 1'b0;
      master_lds = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("wait.ack_clr", 32'(master_ack), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
